// File: rtl/decode_execute_stage_if.sv
// Bundle between decode, the E-stage register and the forwarding sources.
//   Decode side   : stall, flush, valid_d, RD1_d/RD2_d, A1_d/A2_d/A3_d, Imm_d, control bits.
//   Forwarding    : ALUResult_m/WA3_m/RegWrite_m (memory), Result_w/WA3_w/RegWrite_w (writeback).
//   Execute side  : SrcA_e, SrcB_e, WriteData_e, WA3_e, control bits, valid_e, load_stall.
// master drives decode/forwarding inputs and observes E outputs; slave is the stage itself.
interface decode_execute_stage_if #(
  parameter int unsigned N = 32
);
  logic         stall;
  logic         flush;
  logic         valid_d;
  logic [N-1:0] RD1_d;
  logic [N-1:0] RD2_d;
  logic [3:0]   A1_d;
  logic [3:0]   A2_d;
  logic [3:0]   A3_d;
  logic [N-1:0] Imm_d;
  logic         RegWrite_d;
  logic         MemWrite_d;
  logic         MemtoReg_d;
  logic         ALUSrc_d;
  logic [1:0]   ALUControl_d;

  logic [N-1:0] ALUResult_m;
  logic [3:0]   WA3_m;
  logic         RegWrite_m;
  logic [N-1:0] Result_w;
  logic [3:0]   WA3_w;
  logic         RegWrite_w;

  logic [N-1:0] SrcA_e;
  logic [N-1:0] SrcB_e;
  logic [N-1:0] WriteData_e;
  logic [3:0]   WA3_e;
  logic         RegWrite_e;
  logic         MemWrite_e;
  logic         MemtoReg_e;
  logic [1:0]   ALUControl_e;
  logic         valid_e;
  logic         load_stall;

  modport master (
    output stall, flush, valid_d, RD1_d, RD2_d, A1_d, A2_d, A3_d, Imm_d,
           RegWrite_d, MemWrite_d, MemtoReg_d, ALUSrc_d, ALUControl_d,
           ALUResult_m, WA3_m, RegWrite_m, Result_w, WA3_w, RegWrite_w,
    input  SrcA_e, SrcB_e, WriteData_e, WA3_e, RegWrite_e, MemWrite_e, MemtoReg_e,
           ALUControl_e, valid_e, load_stall
  );

  modport slave (
    input  stall, flush, valid_d, RD1_d, RD2_d, A1_d, A2_d, A3_d, Imm_d,
           RegWrite_d, MemWrite_d, MemtoReg_d, ALUSrc_d, ALUControl_d,
           ALUResult_m, WA3_m, RegWrite_m, Result_w, WA3_w, RegWrite_w,
    output SrcA_e, SrcB_e, WriteData_e, WA3_e, RegWrite_e, MemWrite_e, MemtoReg_e,
           ALUControl_e, valid_e, load_stall
  );
endinterface

// File: rtl/decode_execute_stage.sv
// Decode/execute pipeline register with M/W operand forwarding and load-use detection.
//   clk   : clock, all state changes on the rising edge
//   rst   : synchronous active-high reset, clears the stage to an empty bubble
//   io_de : decode_execute_stage_if.slave -- decode inputs, stall/flush, M/W forwarding
//           sources in; forwarded operands, E-stage control and load_stall out
module decode_execute_stage #(
  parameter int unsigned N = 32
) (
  input logic                         clk,
  input logic                         rst,
  decode_execute_stage_if.slave       io_de
);

  // R15 holds the PC; its reads are never satisfied by forwarding.
  localparam logic [3:0] PcReg = 4'hF;

  logic         r_valid;
  logic [N-1:0] r_rd1;
  logic [N-1:0] r_rd2;
  logic [3:0]   r_a1;
  logic [3:0]   r_a2;
  logic [3:0]   r_a3;
  logic [N-1:0] r_imm;
  logic         r_regwrite;
  logic         r_memwrite;
  logic         r_memtoreg;
  logic         r_alusrc;
  logic [1:0]   r_aluctrl;

  logic [N-1:0] w_fwd_a;
  logic [N-1:0] w_fwd_b;

  always_ff @(posedge clk) begin
    if (rst || io_de.flush) begin
      r_valid    <= 1'b0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_a1       <= '0;
      r_a2       <= '0;
      r_a3       <= '0;
      r_imm      <= '0;
      r_regwrite <= 1'b0;
      r_memwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_alusrc   <= 1'b0;
      r_aluctrl  <= '0;
    end else if (!io_de.stall) begin
      r_valid    <= io_de.valid_d;
      r_rd1      <= io_de.RD1_d;
      r_rd2      <= io_de.RD2_d;
      r_a1       <= io_de.A1_d;
      r_a2       <= io_de.A2_d;
      r_a3       <= io_de.A3_d;
      r_imm      <= io_de.Imm_d;
      // An empty decode slot enters as a bubble: no side effects downstream.
      r_regwrite <= io_de.valid_d & io_de.RegWrite_d;
      r_memwrite <= io_de.valid_d & io_de.MemWrite_d;
      r_memtoreg <= io_de.valid_d & io_de.MemtoReg_d;
      r_alusrc   <= io_de.valid_d & io_de.ALUSrc_d;
      r_aluctrl  <= io_de.valid_d ? io_de.ALUControl_d : 2'b00;
    end
  end

  // Memory stage is younger than writeback, so it wins when both match.
  always_comb begin
    w_fwd_a = r_rd1;
    if (io_de.RegWrite_m && (io_de.WA3_m == r_a1) && (r_a1 != PcReg)) begin
      w_fwd_a = io_de.ALUResult_m;
    end else if (io_de.RegWrite_w && (io_de.WA3_w == r_a1) && (r_a1 != PcReg)) begin
      w_fwd_a = io_de.Result_w;
    end
  end

  always_comb begin
    w_fwd_b = r_rd2;
    if (io_de.RegWrite_m && (io_de.WA3_m == r_a2) && (r_a2 != PcReg)) begin
      w_fwd_b = io_de.ALUResult_m;
    end else if (io_de.RegWrite_w && (io_de.WA3_w == r_a2) && (r_a2 != PcReg)) begin
      w_fwd_b = io_de.Result_w;
    end
  end

  assign io_de.SrcA_e       = w_fwd_a;
  assign io_de.SrcB_e       = r_alusrc ? r_imm : w_fwd_b;
  assign io_de.WriteData_e  = w_fwd_b;
  assign io_de.WA3_e        = r_a3;
  assign io_de.RegWrite_e   = r_regwrite;
  assign io_de.MemWrite_e   = r_memwrite;
  assign io_de.MemtoReg_e   = r_memtoreg;
  assign io_de.ALUControl_e = r_aluctrl;
  assign io_de.valid_e      = r_valid;

  // A load in E cannot forward to a dependent instruction in decode this cycle.
  assign io_de.load_stall = r_valid && r_memtoreg && r_regwrite && io_de.valid_d &&
                            ((io_de.A1_d == r_a3) || (io_de.A2_d == r_a3));

endmodule
